// File: rtl/sata_bist_pkg.sv
// Shared types and constants for the SATA BIST transmit sequencer.
package sata_bist_pkg;

  localparam int unsigned LEN_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SEED,
    RUN,
    DONE
  } bist_state_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_ABORT    = 2'd1,
    ST_ZERO_LEN = 2'd2,
    ST_STALL    = 2'd3
  } bist_status_e;

endpackage

// File: rtl/sata_bist_stall_timer.sv
// Counts consecutive stalled slot cycles; hit_o marks the cycle that reaches STALL_MAX.
module sata_bist_stall_timer #(
  parameter int unsigned STALL_MAX = 1024,
  parameter int unsigned STALL_W   = 11
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam logic [STALL_W-1:0] HitVal = STALL_W'(STALL_MAX - 1);

  logic [STALL_W-1:0] cnt_q, cnt_d;

  // Any non-stall cycle (handshake, idle slot, other state) restarts the count.
  always_comb begin
    cnt_d = inc_i ? cnt_q + STALL_W'(1) : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = inc_i && (cnt_q == HitVal);

endmodule

// File: rtl/sata_bist_sched.sv
// Sequences one BIST transmit run: seeds the pacing LFSR, turns its pulse into a
// valid/ready dword-slot stream, and reports completion status and sent count.
module sata_bist_sched
  import sata_bist_pkg::*;
#(
  parameter logic [31:0] LEVEL_DEF = 32'h0000_0000,
  parameter int unsigned STALL_MAX = 1024,
  parameter int unsigned STALL_W   = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic [31:0]      cfg_level_i,
  output logic [31:0]      lfsr_level_o,
  output logic             lfsr_rst_n_o,
  input  logic             pulse_i,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic             tx_last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       status_o,
  output logic [LEN_W-1:0] sent_cnt_o
);

  bist_state_e  state_q, state_d;
  bist_status_e status_q, status_d;
  logic [LEN_W-1:0] rem_q, rem_d, sent_q, sent_d, rem_after;
  logic [31:0]      level_q, level_d;
  logic tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
  logic busy_q, busy_d, done_q, done_d, lfsr_rst_n_q, lfsr_rst_n_d;
  logic hs, final_hs, go, zero_start, stall_inc, stall_hit;

  assign hs         = tx_valid_q && tx_ready_i;
  assign rem_after  = rem_q - LEN_W'(hs);
  assign final_hs   = hs && (rem_q == LEN_W'(1));
  assign go         = (state_q == IDLE) && start_i && (cfg_len_i != '0);
  assign zero_start = (state_q == IDLE) && start_i && (cfg_len_i == '0);
  assign stall_inc  = (state_q == RUN) && tx_valid_q && !tx_ready_i;

  sata_bist_stall_timer #(
    .STALL_MAX (STALL_MAX),
    .STALL_W   (STALL_W)
  ) u_stall_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc),
    .hit_o (stall_hit)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go) state_d = SEED;
      SEED:    state_d = abort_i ? DONE : RUN;
      RUN:     if (final_hs || abort_i || stall_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rem_d        = rem_q;
    sent_d       = sent_q;
    status_d     = status_q;
    level_d      = level_q;
    tx_valid_d   = 1'b0;
    tx_last_d    = 1'b0;
    done_d       = (state_d == DONE) || zero_start;
    busy_d       = (state_d != IDLE);
    lfsr_rst_n_d = (state_d == SEED) || (state_d == RUN);
    unique case (state_q)
      IDLE: begin
        if (go) begin
          rem_d    = cfg_len_i;
          level_d  = cfg_level_i;
          sent_d   = '0;
          status_d = ST_OK;
        end else if (zero_start) begin
          sent_d   = '0;
          status_d = ST_ZERO_LEN;
        end
      end
      SEED: if (abort_i) status_d = ST_ABORT;
      RUN: begin
        if (hs) begin
          rem_d  = rem_after;
          sent_d = sent_q + LEN_W'(1);
        end
        // Final handshake outranks a coincident abort.
        if (final_hs) begin
          status_d = ST_OK;
        end else if (abort_i) begin
          status_d = ST_ABORT;
        end else if (stall_hit) begin
          status_d = ST_STALL;
        end else begin
          tx_valid_d = (tx_valid_q && !tx_ready_i) || (pulse_i && (rem_after != '0));
          tx_last_d  = tx_valid_d && (rem_after == LEN_W'(1));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q        <= '0;
      sent_q       <= '0;
      status_q     <= ST_OK;
      level_q      <= LEVEL_DEF;
      tx_valid_q   <= 1'b0;
      tx_last_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      lfsr_rst_n_q <= 1'b0;
    end else begin
      rem_q        <= rem_d;
      sent_q       <= sent_d;
      status_q     <= status_d;
      level_q      <= level_d;
      tx_valid_q   <= tx_valid_d;
      tx_last_q    <= tx_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      lfsr_rst_n_q <= lfsr_rst_n_d;
    end
  end

  assign lfsr_level_o = level_q;
  assign lfsr_rst_n_o = lfsr_rst_n_q;
  assign tx_valid_o   = tx_valid_q;
  assign tx_last_o    = tx_last_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign status_o     = status_q;
  assign sent_cnt_o   = sent_q;

endmodule

// File: tb/tb_sata_bist_sched.sv
// Directed self-checking bench for sata_bist_sched; the bench drives pulse directly.
module tb_sata_bist_sched;

  logic        clk = 1'b0;
  logic        rst, start, abort, pulse, tx_ready;
  logic [31:0] cfg_len, cfg_level;
  logic [31:0] lfsr_level, sent_cnt;
  logic        lfsr_rst_n, tx_valid, tx_last, busy, done;
  logic [1:0]  status;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sata_bist_sched #(
    .LEVEL_DEF (32'h0000_0000),
    .STALL_MAX (16),
    .STALL_W   (5)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .abort_i      (abort),
    .cfg_len_i    (cfg_len),
    .cfg_level_i  (cfg_level),
    .lfsr_level_o (lfsr_level),
    .lfsr_rst_n_o (lfsr_rst_n),
    .pulse_i      (pulse),
    .tx_valid_o   (tx_valid),
    .tx_ready_i   (tx_ready),
    .tx_last_o    (tx_last),
    .busy_o       (busy),
    .done_o       (done),
    .status_o     (status),
    .sent_cnt_o   (sent_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Start in cycle 0, abort in cycle abort_c; done is expected the cycle after.
  task automatic run_abort(input int abort_c, input logic [31:0] exp_st,
                           input logic [31:0] exp_sent, input string tag);
    cfg_len = 3; cfg_level = 0; tx_ready = 1; pulse = 1;
    for (int c = 0; c <= 8; c++) begin
      if (c == abort_c + 1) begin
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_status"}, 32'(status), exp_st);
        check_eq({tag, "_sent"}, sent_cnt, exp_sent);
        check_eq({tag, "_valid"}, 32'(tx_valid), 32'd0);
      end
      start = (c == 0);
      abort = (c == abort_c);
      cyc();
    end
    start = 0; abort = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hs, held_err, last_err, last_hs_c, done_c;
    logic pv, pr, seen_done;

    rst = 1; start = 0; abort = 0; pulse = 1; tx_ready = 1;
    cfg_len = 0; cfg_level = 0;
    repeat (3) cyc();

    // Reset values
    check_eq("rst_rst_n", 32'(lfsr_rst_n), 32'd0);
    check_eq("rst_level", lfsr_level, 32'h0);
    check_eq("rst_flags", {27'd0, tx_valid, tx_last, busy, done, 1'b0}, 32'd0);
    check_eq("rst_status", 32'(status), 32'd0);
    check_eq("rst_sent", sent_cnt, 32'd0);
    rst = 0;
    cyc();

    // Full rate, with an ignored start (len 0) while busy in cycle 5
    tx_ready = 1; pulse = 1; cfg_level = 0;
    for (int c = 0; c <= 12; c++) begin
      check_eq($sformatf("full_c%0d", c),
               {27'd0, tx_valid, tx_last, done, busy, lfsr_rst_n},
               {27'd0, 1'(c >= 3 && c <= 10), 1'(c == 10), 1'(c == 11),
                1'(c >= 1 && c <= 11), 1'(c >= 1 && c <= 10)});
      if (c == 11) begin
        check_eq("full_status", 32'(status), 32'd0);
        check_eq("full_sent", sent_cnt, 32'd8);
      end
      start   = (c == 0) || (c == 5);
      cfg_len = (c == 5) ? 32'd0 : 32'd8;
      cyc();
    end
    start = 0;

    // Backpressure: ready toggles every cycle
    cfg_len = 4; hs = 0; held_err = 0; last_err = 0; pv = 0; pr = 0; seen_done = 0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (pv && !pr && !tx_valid) held_err++;
      if (tx_last && !tx_valid) last_err++;
      if (done) begin
        seen_done = 1;
      end else begin
        tx_ready = (c % 2 == 0);
        if (tx_valid && tx_ready) begin
          hs++;
          if (tx_last != (hs == 4)) last_err++;
        end
        pv = tx_valid; pr = tx_ready;
        start = (c == 0);
        cyc();
      end
    end
    start = 0; tx_ready = 1;
    check_eq("bp_done_seen", 32'(seen_done), 32'd1);
    check_eq("bp_handshakes", 32'(hs), 32'd4);
    check_eq("bp_valid_held", 32'(held_err), 32'd0);
    check_eq("bp_last", 32'(last_err), 32'd0);
    check_eq("bp_status", 32'(status), 32'd0);
    check_eq("bp_sent", sent_cnt, 32'd4);
    cyc();

    // Zero length, with abort held high (ignored in IDLE)
    cfg_len = 0; abort = 1;
    for (int c = 0; c <= 3; c++) begin
      check_eq($sformatf("zl_busy_c%0d", c), 32'(busy), 32'd0);
      check_eq($sformatf("zl_done_c%0d", c), 32'(done), 32'(c == 1));
      if (c == 1) begin
        check_eq("zl_status", 32'(status), 32'd2);
        check_eq("zl_sent", sent_cnt, 32'd0);
      end
      start = (c == 0);
      cyc();
    end
    start = 0; abort = 0;

    // Stall: ready drops after two handshakes
    cfg_len = 10; hs = 0; last_hs_c = -1; done_c = -1; seen_done = 0;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      if (done) begin
        seen_done = 1;
        done_c = c;
        check_eq("stall_status", 32'(status), 32'd3);
        check_eq("stall_sent", sent_cnt, 32'd2);
      end else begin
        tx_ready = (hs < 2);
        if (tx_valid && tx_ready) begin
          hs++;
          last_hs_c = c;
        end
        start = (c == 0);
        cyc();
      end
    end
    start = 0;
    check_eq("stall_done_seen", 32'(seen_done), 32'd1);
    check_eq("stall_latency", 32'(done_c - last_hs_c), 32'd17);
    cyc();
    check_eq("stall_valid_after", 32'(tx_valid), 32'd0);
    tx_ready = 1;
    cyc();

    // Abort colliding with final and non-final handshakes
    run_abort(5, 32'd0, 32'd3, "abort_final");
    run_abort(4, 32'd1, 32'd2, "abort_mid");

    // Asynchronous reset mid-run
    cfg_len = 100; cfg_level = 32'h1234_5678; tx_ready = 1; pulse = 1;
    for (int c = 0; c < 5; c++) begin
      start = (c == 0);
      cyc();
    end
    start = 0;
    check_eq("mid_valid", 32'(tx_valid), 32'd1);
    check_eq("mid_level", lfsr_level, 32'h1234_5678);
    #2 rst = 1;
    #1;
    check_eq("arst_rst_n", 32'(lfsr_rst_n), 32'd0);
    check_eq("arst_valid", 32'(tx_valid), 32'd0);
    check_eq("arst_level", lfsr_level, 32'h0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    cyc();
    rst = 0;
    cyc();

    // Slow pacing: slots only follow pulse
    cfg_len = 2; cfg_level = 32'hFFFF_FFFF; tx_ready = 1;
    for (int c = 0; c <= 18; c++) begin
      check_eq($sformatf("pace_c%0d", c), {29'd0, tx_valid, tx_last, done},
               {29'd0, 1'(c == 13 || c == 16), 1'(c == 16), 1'(c == 17)});
      if (c == 5) check_eq("pace_level", lfsr_level, 32'hFFFF_FFFF);
      if (c == 17) begin
        check_eq("pace_status", 32'(status), 32'd0);
        check_eq("pace_sent", sent_cnt, 32'd2);
      end
      if (c == 18) check_eq("pace_level_hold", lfsr_level, 32'hFFFF_FFFF);
      pulse = (c == 12) || (c == 15);
      start = (c == 0);
      cyc();
    end
    start = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
